// File: rtl/llc_lookup_arbiter.sv
// Round-robin arbiter for the shared LLC tag/state lookup pipeline, with set-hazard blocking via an in-order in-flight table.
// Optional build macro LLC_ARB_RSP_PRIO_EN: requester 0 gets fixed priority over the round-robin group.
module llc_lookup_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int SRC_BITS     = 2,
    parameter int SET_BITS     = 9,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*SET_BITS-1:0]   req_set,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SET_BITS-1:0]           out_set,
    output logic [SRC_BITS-1:0]           out_src,
    input  logic                          retire_valid,
    output logic [$clog2(MAX_INFLIGHT):0] inflight_cnt,
    output logic                          err_retire_empty
);
    localparam int PTR_BITS = $clog2(MAX_INFLIGHT);
    localparam int CNT_BITS = PTR_BITS + 1;

    logic [MAX_INFLIGHT-1:0] r_tbl_valid;
    logic [SET_BITS-1:0]     r_tbl_set [MAX_INFLIGHT];
    logic [PTR_BITS-1:0]     r_head;
    logic [PTR_BITS-1:0]     r_tail;
    logic [CNT_BITS-1:0]     r_cnt;
    logic [SRC_BITS-1:0]     r_rr_ptr;
    logic                    r_out_valid;
    logic [SET_BITS-1:0]     r_out_set;
    logic [SRC_BITS-1:0]     r_out_src;
    logic                    r_err;

    logic [NUM_REQ-1:0]      w_elig;
    logic [NUM_REQ-1:0]      w_rr_elig;
    logic                    w_found;
    logic [SRC_BITS-1:0]     w_gnt_idx;
    logic                    w_can_grant;
    logic                    w_grant;
    logic                    w_rr_update;
    logic                    w_retire;
    logic [SET_BITS-1:0]     w_gnt_set;

    // A requester is blocked if its set matches any valid entry, including one retiring this cycle.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_hazard
            logic [MAX_INFLIGHT-1:0] w_hit;
            for (gj = 0; gj < MAX_INFLIGHT; gj++) begin : g_entry
                assign w_hit[gj] = r_tbl_valid[gj] &&
                                   (r_tbl_set[gj] == req_set[SET_BITS*(gi+1)-1 -: SET_BITS]);
            end
            assign w_elig[gi] = req_valid[gi] && !(|w_hit);
        end
    endgenerate

`ifdef LLC_ARB_RSP_PRIO_EN
    assign w_rr_elig = w_elig & ~NUM_REQ'(1);
`else
    assign w_rr_elig = w_elig;
`endif

    always_comb begin : p_arb
        logic [SRC_BITS-1:0] scan;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = r_rr_ptr + SRC_BITS'(k);
            if (!w_found && w_rr_elig[scan]) begin
                w_found   = 1'b1;
                w_gnt_idx = scan;
            end
        end
`ifdef LLC_ARB_RSP_PRIO_EN
        if (w_elig[0]) begin
            w_found   = 1'b1;
            w_gnt_idx = '0;
        end
`endif
    end

    assign w_can_grant = !rst && (!r_out_valid || out_ready) &&
                         (r_cnt < CNT_BITS'(MAX_INFLIGHT));
    assign w_grant     = w_can_grant && w_found;
    assign w_gnt_set   = req_set[w_gnt_idx*SET_BITS +: SET_BITS];
    assign w_retire    = retire_valid && (r_cnt != '0);
    assign req_ready   = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;

`ifdef LLC_ARB_RSP_PRIO_EN
    assign w_rr_update = w_grant && (w_gnt_idx != '0);
`else
    assign w_rr_update = w_grant;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tbl_valid <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_cnt       <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_set   <= '0;
            r_out_src   <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_grant) begin
                r_out_valid         <= 1'b1;
                r_out_set           <= w_gnt_set;
                r_out_src           <= w_gnt_idx;
                r_tbl_valid[r_tail] <= 1'b1;
                r_tbl_set[r_tail]   <= w_gnt_set;
                r_tail              <= r_tail + 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_rr_update)
                r_rr_ptr <= w_gnt_idx + 1'b1;

            // head and tail only coincide when empty or full, so these writes never collide
            if (w_retire) begin
                r_tbl_valid[r_head] <= 1'b0;
                r_head              <= r_head + 1'b1;
            end

            if (retire_valid && (r_cnt == '0))
                r_err <= 1'b1;

            case ({w_grant, w_retire})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign out_valid        = r_out_valid;
    assign out_set          = r_out_set;
    assign out_src          = r_out_src;
    assign inflight_cnt     = r_cnt;
    assign err_retire_empty = r_err;

endmodule
